// File: rtl/a0_trace_pkg.sv
// Shared widths and the trace entry layout for the a0 change tracer.
package a0_trace_pkg;

    localparam int unsigned TRACE_DATA_W  = 32;
    localparam int unsigned TRACE_STAMP_W = 16;
    localparam int unsigned TRACE_DEPTH   = 8;
    localparam int unsigned TRACE_CNT_W   = 8;

    typedef struct packed {
        logic [TRACE_STAMP_W-1:0] stamp;
        logic [TRACE_DATA_W-1:0]  data;
    } trace_entry_t;

endpackage

// File: rtl/a0_trace_sync_fifo.sv
// First-word-fall-through FIFO; the head holds the last popped word while empty.
module sync_fifo
    import a0_trace_pkg::*;
#(
    parameter int unsigned WIDTH = TRACE_STAMP_W + TRACE_DATA_W,
    parameter int unsigned DEPTH = TRACE_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_last;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = w_empty ? r_last : r_mem[r_rd_ptr];
    assign o_valid = !w_empty;
    assign o_full  = w_full;
    assign o_level = r_level;

endmodule

// File: rtl/a0_trace.sv
// Watches a0 for changes, queues each change with a cycle stamp, and streams
// the queue out over valid/ready so a slow consumer never stalls the core.
module a0_trace
    import a0_trace_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = TRACE_DATA_W,
    parameter int unsigned STAMP_WIDTH = TRACE_STAMP_W,
    parameter int unsigned DEPTH       = TRACE_DEPTH,
    parameter int unsigned CNT_WIDTH   = TRACE_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DATA_WIDTH-1:0]  a0_in,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [STAMP_WIDTH-1:0] out_stamp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_WIDTH-1:0]   dropped
);

    logic [STAMP_WIDTH-1:0] r_stamp;
    logic [DATA_WIDTH-1:0]  r_prev;
    logic                   r_first;
    logic [CNT_WIDTH-1:0]   r_dropped;

    logic                              w_event;
    logic                              w_pop;
    logic                              w_full;
    logic                              w_drop;
    logic [STAMP_WIDTH+DATA_WIDTH-1:0] w_head;

    // The first enabled sample always counts as a change.
    assign w_event = en && (r_first || (a0_in != r_prev));
    assign w_pop   = out_valid && out_ready;
    assign w_drop  = w_event && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stamp   <= '0;
            r_prev    <= '0;
            r_first   <= 1'b1;
            r_dropped <= '0;
        end else begin
            r_stamp <= r_stamp + 1'b1;
            if (en) begin
                r_prev  <= a0_in;
                r_first <= 1'b0;
            end
            if (w_drop && (r_dropped != '1)) begin
                r_dropped <= r_dropped + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (STAMP_WIDTH + DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_event),
        .i_data  ({r_stamp, a0_in}),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_valid (out_valid),
        .o_full  (w_full),
        .o_level (level)
    );

    assign {out_stamp, out_data} = w_head;
    assign dropped = r_dropped;

endmodule
